// File: rtl/press_classifier_pkg.sv
// Shared types and helpers for the push-button press classifier.
package press_pkg;

  typedef logic [2:0] state_e;

  localparam state_e IDLE      = 3'd0;
  localparam state_e PRESS1    = 3'd1;
  localparam state_e WAIT_GAP  = 3'd2;
  localparam state_e PRESS2    = 3'd3;
  localparam state_e LONG_HELD = 3'd4;

  function automatic int cycles_per_ms(input int clk_freq);
    return clk_freq / 1000;
  endfunction

endpackage

// File: rtl/press_classifier_if.sv
// Bundle between the debouncer, the classifier and the control logic above it.
interface press_if;
  import press_pkg::*;

  // db_tick_i is a one-cycle pulse on the first pressed cycle; every event
  // output is a one-cycle pulse with no back-pressure, held_o is a level.
  logic   db_level_i;
  logic   db_tick_i;
  logic   short_o;
  logic   long_o;
  logic   double_o;
  logic   held_o;
  state_e state;

  modport master (
    output db_level_i, db_tick_i,
    input  short_o, long_o, double_o, held_o, state
  );

  modport slave (
    input  db_level_i, db_tick_i,
    output short_o, long_o, double_o, held_o, state
  );

endinterface

// File: rtl/press_classifier_ms_timer.sv
// Millisecond timer: cycle prescaler feeding a saturating ms counter.
module ms_timer #(
  parameter int CyclesPerMs = 100_000,
  parameter int MaxMs       = 1000
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clr_i,
  output logic [$clog2(MaxMs+1)-1:0]   ms_o,
  output logic                         wrap_o
);

  localparam int MsW  = $clog2(MaxMs + 1);
  localparam int PreW = (CyclesPerMs > 1) ? $clog2(CyclesPerMs) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(CyclesPerMs - 1);
  localparam logic [MsW-1:0]  MsMax   = MsW'(MaxMs);

  logic [PreW-1:0] pre_q;
  logic [MsW-1:0]  ms_q;

  // wrap_o marks the cycle whose closing edge completes another millisecond
  assign wrap_o = (pre_q == PreLast);
  assign ms_o   = ms_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else if (clr_i) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else begin
      pre_q <= wrap_o ? '0 : pre_q + 1'b1;
      if (wrap_o && (ms_q != MsMax)) begin
        ms_q <= ms_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/press_classifier.sv
// Classifies debounced button activity into short, long and double press pulses.
module press_classifier
  import press_pkg::*;
#(
  parameter int ClkFreq    = 100_000_000,
  parameter int LongTimeMs = 1000,
  parameter int GapTimeMs  = 250
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  press_if.slave bus
);

  localparam int CyclesPerMs = cycles_per_ms(ClkFreq);
  localparam int MaxMs       = (LongTimeMs > GapTimeMs) ? LongTimeMs : GapTimeMs;
  localparam int MsW         = $clog2(MaxMs + 1);
  localparam logic [MsW-1:0] LongLast = MsW'(LongTimeMs - 1);
  localparam logic [MsW-1:0] GapLast  = MsW'(GapTimeMs - 1);

  state_e           state_q, state_d;
  logic             level_q;
  logic             release_w;
  logic [MsW-1:0]   ms;
  logic             wrap;
  logic             reach_long, gap_expire, clr;
  logic             short_d, long_d, double_d;
  logic             short_q, long_q, double_q, held_q;

  assign release_w = level_q & ~bus.db_level_i;
  // Thresholds fire on the edge that completes the last millisecond
  assign reach_long = wrap && (ms == LongLast);
  assign gap_expire = wrap && (ms == GapLast);
  assign clr        = (state_d != state_q);

  ms_timer #(
    .CyclesPerMs (CyclesPerMs),
    .MaxMs       (MaxMs)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr),
    .ms_o   (ms),
    .wrap_o (wrap)
  );

  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.db_tick_i) state_d = PRESS1;
      end
      PRESS1: begin
        // Long wins over a coincident release, which then skips LONG_HELD
        if (reach_long) begin
          long_d  = 1'b1;
          state_d = release_w ? IDLE : LONG_HELD;
        end else if (release_w) begin
          state_d = WAIT_GAP;
        end
      end
      LONG_HELD: begin
        if (release_w) state_d = IDLE;
      end
      WAIT_GAP: begin
        if (bus.db_tick_i) begin
          double_d = 1'b1;
          state_d  = PRESS2;
        end else if (gap_expire) begin
          short_d = 1'b1;
          state_d = IDLE;
        end
      end
      PRESS2: begin
        if (release_w) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      level_q  <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= bus.db_level_i;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      held_q   <= (state_d == LONG_HELD);
    end
  end

  assign bus.short_o  = short_q;
  assign bus.long_o   = long_q;
  assign bus.double_o = double_q;
  assign bus.held_o   = held_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier at 10 cycles/ms, long 20 ms, gap 5 ms.
module tb_press_classifier;
  import press_pkg::*;

  logic clk;
  logic rst_n;
  int   edge_n;
  int   n_vec;
  int   n_err;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  press_if bus ();

  press_classifier #(
    .ClkFreq    (10_000),
    .LongTimeMs (20),
    .GapTimeMs  (5)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // event monitor: kind 1 = short, 2 = long, 3 = double, tagged with edge index
  always @(negedge clk) begin
    if (bus.short_o)  obs_q.push_back({2'd1, edge_n[29:0]});
    if (bus.long_o)   obs_q.push_back({2'd2, edge_n[29:0]});
    if (bus.double_o) obs_q.push_back({2'd3, edge_n[29:0]});
  end

  function automatic logic [31:0] ev(input logic [1:0] kind, input int e);
    return {kind, e[29:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic scoreboard(input string tag);
    int n;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_ev%0d", tag, i), obs_q[i], exp_q[i]);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int e);
    while (edge_n < e) step();
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(output int t);
    bus.db_level_i = 1'b1;
    bus.db_tick_i  = 1'b1;
    t = edge_n + 1;
    step();
    bus.db_tick_i  = 1'b0;
  endtask

  task automatic release_btn(output int r);
    bus.db_level_i = 1'b0;
    r = edge_n + 1;
  endtask

  int t, t2, r, r2;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.db_level_i = 1'b0;
    bus.db_tick_i  = 1'b0;

    // reset held while the input toggles
    for (int i = 0; i < 6; i++) begin
      step();
      bus.db_level_i = ~bus.db_level_i;
      bus.db_tick_i  = bus.db_level_i;
      #2;
      check($sformatf("rst_out%0d", i),
            {28'd0, bus.short_o, bus.long_o, bus.double_o, bus.held_o}, 32'd0);
    end
    check("rst_state", bus.state, IDLE);
    step();
    bus.db_level_i = 1'b0;
    bus.db_tick_i  = 1'b0;
    rst_n = 1'b1;
    wait_cycles(100);
    scoreboard("idle");

    // short press
    press(t);
    wait_to(t + 29);
    release_btn(r);
    exp_q.push_back(ev(2'd1, r + 50));
    wait_cycles(80);
    check("short_state", bus.state, IDLE);
    scoreboard("short");

    // long press
    press(t);
    wait_to(t + 199);
    check("long_held_pre", bus.held_o, 1'b0);
    step();
    check("long_held_rise", bus.held_o, 1'b1);
    check("long_pulse", bus.long_o, 1'b1);
    wait_to(t + 299);
    release_btn(r);
    check("long_held_hold", bus.held_o, 1'b1);
    step();
    check("long_held_fall", bus.held_o, 1'b0);
    exp_q.push_back(ev(2'd2, t + 200));
    wait_cycles(80);
    scoreboard("long");

    // double press, second hold is long but unreported
    press(t);
    wait_to(t + 19);
    release_btn(r);
    wait_to(r + 29);
    press(t2);
    exp_q.push_back(ev(2'd3, t2));
    wait_to(t2 + 299);
    check("double_no_held", bus.held_o, 1'b0);
    release_btn(r2);
    wait_cycles(80);
    scoreboard("double");

    // second tick exactly on gap expiry: press wins
    press(t);
    wait_to(t + 19);
    release_btn(r);
    wait_to(r + 49);
    press(t2);
    exp_q.push_back(ev(2'd3, r + 50));
    wait_to(t2 + 9);
    release_btn(r2);
    wait_cycles(80);
    scoreboard("gap_edge");

    // second tick one cycle late: short, then a fresh press
    press(t);
    wait_to(t + 19);
    release_btn(r);
    wait_to(r + 50);
    press(t2);
    check("gap_late_state", bus.state, PRESS1);
    wait_to(t2 + 9);
    release_btn(r2);
    exp_q.push_back(ev(2'd1, r + 50));
    exp_q.push_back(ev(2'd1, r2 + 50));
    wait_cycles(80);
    scoreboard("gap_late");

    // reset in the middle of a hold
    press(t);
    wait_to(t + 150);
    rst_n = 1'b0;
    #2;
    check("midrst_state", bus.state, IDLE);
    check("midrst_out", {28'd0, bus.short_o, bus.long_o, bus.double_o, bus.held_o}, 32'd0);
    wait_cycles(5);
    rst_n = 1'b1;
    wait_to(t + 300);
    check("midrst_held", bus.held_o, 1'b0);
    release_btn(r);
    wait_cycles(80);
    press(t);
    wait_to(t + 29);
    release_btn(r);
    exp_q.push_back(ev(2'd1, r + 50));
    wait_cycles(80);
    scoreboard("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/press_classifier.md
# press_classifier

Classifies debounced push-button activity into single-cycle short-press, long-press and double-press events. It sits directly downstream of the debouncer and consumes its `db_level_o`/`db_tick_o` outputs. Its event pulses drive the control logic above it. All timing is counted in milliseconds derived from the system clock, so thresholds stay valid across clock frequencies.

## Interface
Parameters:
- `ClkFreq`, default 100_000_000: clock frequency in Hz. Must be a multiple of 1000.
- `LongTimeMs`, default 1000: hold time in ms that qualifies a long press. Must be ≥1.
- `GapTimeMs`, default 250: maximum release-to-press gap in ms for a double press. Must be ≥1.

Ports:
- `clk_i` in 1: system clock. Single clock domain.
- `rst_ni` in 1: asynchronous, active-low reset.
- `db_level_i` in 1: debounced button level, 1 = pressed.
- `db_tick_i` in 1: one-cycle pulse marking the 0→1 transition of `db_level_i`. It is coincident with the first cycle `db_level_i`=1.
- `short_o` out 1: one-cycle pulse, single short press completed.
- `long_o` out 1: one-cycle pulse, hold reached `LongTimeMs`.
- `double_o` out 1: one-cycle pulse, second press within the gap.
- `held_o` out 1: level, high while a qualified long press remains held.

## Operation
- Derived constant: `CyclesPerMs` = `ClkFreq`/1000.
- Prescaler width: $clog2(`CyclesPerMs`).
- ms counter width: $clog2(max(`LongTimeMs`,`GapTimeMs`)+1). The counter saturates and never wraps.
- Release: `level_q` & ~`db_level_i`, where `level_q` is the registered `db_level_i` (reset 0).
- Timer: the prescaler and ms counter are cleared on every state transition. `elapsed` counts cycles since entry into the current state.
- FSM states and transitions:
  - IDLE: `db_tick_i` → PRESS1.
  - PRESS1:
    - release before `LongTimeMs` → WAIT_GAP.
    - timer reaches `LongTimeMs` while held → LONG_HELD, pulse `long_o`.
  - LONG_HELD: `held_o`=1. Release → IDLE. No further events.
  - WAIT_GAP:
    - `db_tick_i` before `GapTimeMs` expires → PRESS2, pulse `double_o`.
    - gap expiry → IDLE, pulse `short_o`.
  - PRESS2: release → IDLE. A long hold here is not reported. A `db_tick_i` here is ignored.
- Simultaneous `db_tick_i` and gap expiry in WAIT_GAP: the press wins. Result is `double_o`, no `short_o`.
- Release and long-threshold in the same PRESS1 cycle: long wins. Result is `long_o`, then IDLE directly, with `held_o` never asserted.
- `db_tick_i` is honoured only in IDLE and WAIT_GAP.
- At most one of `short_o`/`long_o`/`double_o` is high in any cycle.

## Timing
- All outputs are registered.
- Reset values: state IDLE, counters 0, `level_q` 0, `short_o`/`long_o`/`double_o`/`held_o` 0.
- Reset asserted mid-operation: return to IDLE immediately. In-flight events are discarded, no pulse.
- `long_o` is high in the cycle exactly `LongTimeMs`·`CyclesPerMs` edges after the edge that sampled `db_tick_i`. `held_o` rises in the same cycle.
- `short_o` is high exactly `GapTimeMs`·`CyclesPerMs` edges after the edge that sampled the release.
- `double_o` is high in the cycle after the edge that sampled the second `db_tick_i`.
- `held_o` falls in the cycle after the edge that sampled the release.
- Each event pulse is exactly 1 cycle wide.

## Structure
- Shared package `press_pkg` holds:
  - `state_e`: IDLE, PRESS1, WAIT_GAP, PRESS2, LONG_HELD.
  - `CyclesPerMs` derivation function.
- Natural sub-module: `ms_timer`.
  - Parameterised by `CyclesPerMs` and `MaxMs`.
  - Inputs: `clk_i`, `rst_ni`, `clr_i`.
  - Output: `ms_o`, the saturating elapsed-ms count.
  - Thresholds are compared in `press_classifier`.

## Test plan
All scenarios use `ClkFreq`=10_000 (`CyclesPerMs`=10), `LongTimeMs`=20, `GapTimeMs`=5.
- Reset: hold `rst_ni`=0 with `db_level_i`=1 toggling → all outputs 0. After release of reset, no pulse without `db_tick_i`.
- Short press: press 30 cycles, release → single `short_o` exactly 50 cycles after the release sample. No `long_o`/`double_o`.
- Long press: press and hold 300 cycles → `long_o` pulse at 200 cycles after the tick, `held_o`=1 until the cycle after release. No `short_o` follows.
- Double press: press 20 cycles, release 30 cycles, press again → `double_o` one cycle after the second tick. No `short_o`. A second hold of 300 cycles gives no `long_o`.
- Gap boundary: second tick landing exactly on the 50th cycle after release → `double_o`, no `short_o`. A tick at 51 cycles → `short_o` at 50 cycles, then new PRESS1.
- Reset mid-operation: assert `rst_ni`=0 at cycle 150 of a hold → no `long_o`, `held_o`=0. A new press after reset classifies normally.
